// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared constants and types for the iterative RV32M multiply/divide unit:
// funct3 encodings, the control FSM state type and the iteration count.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // One radix-2 step per clock over a 32-bit operand.
    localparam int ITER_CNT = 32;
    localparam int CNT_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Request/response bundle between execute-stage control (master) and the
// multiply/divide unit (slave).
//   start, kill          : request and abort
//   funct3, op_a, op_b   : RV32M op and register operands
//   rd_in                : destination register of the request
//   busy, done           : pipeline hold and single-cycle writeback strobe
//   result, rd_out       : writeback data and register number
// -----------------------------------------------------------------------------
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, kill, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, kill, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_signfix
// Combinational operand conditioning at accept time. Converts the operands to
// magnitudes according to the signedness of the RV32M op and reports whether
// the final result has to be negated.
//   funct3_i       : RV32M op
//   op_a_i, op_b_i : raw register operands
//   mag_a_o/_b_o   : operand magnitudes fed to the unsigned datapath
//   neg_o          : result sign (product / quotient: sa^sb, remainder: sa)
// -----------------------------------------------------------------------------
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic [XLEN-1:0] mag_a_o,
    output logic [XLEN-1:0] mag_b_o,
    output logic            neg_o
);

    logic sign_a;
    logic sign_b;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (funct3_i)
            F3_MULH, F3_DIV, F3_REM: begin
                sign_a = op_a_i[XLEN-1];
                sign_b = op_b_i[XLEN-1];
            end
            F3_MULHSU: sign_a = op_a_i[XLEN-1];
            default:   ;
        endcase

        mag_a_o = sign_a ? -op_a_i : op_a_i;
        mag_b_o = sign_b ? -op_b_i : op_b_i;
        neg_o   = (funct3_i == F3_REM) ? sign_a : (sign_a ^ sign_b);
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. One radix-2 datapath shared by MUL*,
// DIV* and REM*: 32 CALC iterations, one FIX cycle for sign and word select,
// then a one-cycle DONE strobe. Divide-by-zero and signed overflow are
// resolved at accept and go straight to DONE.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : muldiv_if slave (start/kill/funct3/op_a/op_b/rd_in in,
//                busy/done/result/rd_out out, all outputs registered)
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    muldiv_state_t     state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [2:0]        f3_q,     f3_d;
    logic [4:0]        rd_q,     rd_d;
    logic [XLEN-1:0]   a_q,      a_d;      // multiplicand magnitude
    logic [XLEN-1:0]   b_q,      b_d;      // divisor magnitude
    logic              neg_q,    neg_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;    // product, or dividend/quotient in low half
    logic [XLEN-1:0]   rem_q,    rem_d;    // divide partial remainder
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg;

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .funct3_i (bus.funct3),
        .op_a_i   (bus.op_a),
        .op_b_i   (bus.op_b),
        .mag_a_o  (mag_a),
        .mag_b_o  (mag_b),
        .neg_o    (neg)
    );

    // funct3[2] selects division, [1] picks remainder, [0] clear means signed.
    logic            is_div;
    logic            is_rem;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    assign is_div   = bus.funct3[2];
    assign is_rem   = bus.funct3[1];
    assign div_zero = is_div && (bus.op_b == '0);
    assign div_ovf  = is_div && !bus.funct3[0]
                      && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.op_b == '1);
    assign special_res = div_zero ? (is_rem ? bus.op_a : '1)
                                  : (is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    logic [XLEN:0]     part_rem;   // 33-bit shifted partial remainder
    logic [XLEN:0]     diff;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem_val;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        part_rem = {rem_q, acc_q[XLEN-1]};
        diff     = part_rem - {1'b0, b_q};
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        prod     = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_val  = neg_q ? -rem_q : rem_q;

        if (bus.kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_d = ST_IDLE;
                    if (bus.start) begin
                        f3_d  = bus.funct3;
                        rd_d  = bus.rd_in;
                        a_d   = mag_a;
                        b_d   = mag_b;
                        neg_d = neg;
                        rem_d = '0;
                        cnt_d = '0;
                        // Divide shifts the dividend out of the low half;
                        // multiply shifts the multiplier out of it.
                        acc_d = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                        if (div_zero || div_ovf) begin
                            state_d  = ST_DONE;
                            result_d = special_res;
                            rd_out_d = bus.rd_in;
                        end else begin
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (f3_q[2]) begin
                        // Restoring step: a borrow in diff means divisor did
                        // not fit, so keep the shifted remainder and shift a 0.
                        rem_d = diff[XLEN] ? part_rem[XLEN-1:0] : diff[XLEN-1:0];
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~diff[XLEN]};
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER_CNT - 1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    case (f3_q)
                        F3_MUL:                        result_d = prod[XLEN-1:0];
                        F3_MULH, F3_MULHSU, F3_MULHU:  result_d = prod[2*XLEN-1:XLEN];
                        F3_DIV, F3_DIVU:               result_d = quo;
                        default:                       result_d = rem_val;
                    endcase
                    rd_out_d = rd_q;
                    state_d  = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign bus.busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit. Inputs change on the falling
// edge, outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Present one request, accepted on the next rising edge (E0). Returns #1
    // after E0 with the inputs scrambled to show they are registered.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.funct3 = F3_REMU;
        bus.op_a   = 32'hDEAD_BEEF;
        bus.op_b   = 32'h0BAD_F00D;
        bus.rd_in  = 5'd31;
    endtask

    // Count edges until done is seen (0 if already high), and how many of the
    // samples before it had busy high. Bounded at 80 edges.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 80) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        n_cmp += 4;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        if (bus.result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.result); end
        if (bus.rd_out !== 5'd0) begin n_bad++; $display("FAIL reset_rd: got %0d want 0", bus.rd_out); end
    endtask

    task automatic test_mul_basic();
        int lat, bc;
        issue(F3_MUL, 32'd7, 32'd3, 5'd5);
        wait_done(lat, bc);
        n_cmp += 4;
        // E0 accept, E1..E32 iterate, E33 fix: done seen 33 edges after E0,
        // busy high on every sample from E0 up to E33.
        if (lat !== 33) begin n_bad++; $display("FAIL mul_latency: got %0d want 33", lat); end
        if (bc !== 33) begin n_bad++; $display("FAIL mul_busy_cycles: got %0d want 33", bc); end
        if (bus.result !== 32'd21) begin n_bad++; $display("FAIL mul_result: got %h want 15", bus.result); end
        if (bus.rd_out !== 5'd5) begin n_bad++; $display("FAIL mul_rd: got %0d want 5", bus.rd_out); end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL mul_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_arith();
        logic [2:0]  f3   [10] = '{F3_MULH, F3_MULHU, F3_MULHSU, F3_MUL, F3_MULH,
                                   F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV};
        logic [31:0] va   [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                   32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,
                                   32'd100, 32'd7};
        logic [31:0] vb   [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'd5,
                                   32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE};
        logic [31:0] want [10] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14,
                                   32'd2, 32'hFFFF_FFFD};
        int lat, bc;
        for (int i = 0; i < 10; i++) begin
            issue(f3[i], va[i], vb[i], 5'(i + 10));
            wait_done(lat, bc);
            n_cmp += 3;
            if (lat !== 33) begin n_bad++; $display("FAIL arith%0d_latency: got %0d want 33", i, lat); end
            if (bus.result !== want[i]) begin n_bad++; $display("FAIL arith%0d_result: got %h want %h", i, bus.result, want[i]); end
            if (bus.rd_out !== 5'(i + 10)) begin n_bad++; $display("FAIL arith%0d_rd: got %0d want %0d", i, bus.rd_out, i + 10); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3   [6] = '{F3_DIV, F3_REMU, F3_DIV, F3_REM, F3_DIVU, F3_REM};
        logic [31:0] va   [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
        logic [31:0] vb   [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] want [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        int lat, bc;
        for (int i = 0; i < 6; i++) begin
            issue(f3[i], va[i], vb[i], 5'd20);
            wait_done(lat, bc);
            n_cmp += 4;
            if (lat !== 0) begin n_bad++; $display("FAIL special%0d_latency: got %0d want 0", i, lat); end
            if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL special%0d_busy: got %b want 0", i, bus.busy); end
            if (bus.result !== want[i]) begin n_bad++; $display("FAIL special%0d_result: got %h want %h", i, bus.result, want[i]); end
            if (bus.rd_out !== 5'd20) begin n_bad++; $display("FAIL special%0d_rd: got %0d want 20", i, bus.rd_out); end
            @(posedge clk); #1;
            n_cmp += 2;
            if (bus.done !== 1'b0) begin n_bad++; $display("FAIL special%0d_done_pulse: got %b want 0", i, bus.done); end
            if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL special%0d_busy_after: got %b want 0", i, bus.busy); end
        end
    endtask

    task automatic test_start_ignored();
        int lat, bc;
        issue(F3_MUL, 32'd7, 32'd3, 5'd5);
        repeat (9) @(posedge clk);
        // Request lands on E10, mid-CALC: must be dropped.
        issue(F3_DIVU, 32'd100, 32'd7, 5'd9);
        wait_done(lat, bc);
        n_cmp += 3;
        if (lat !== 23) begin n_bad++; $display("FAIL ignore_latency: got %0d want 23", lat); end
        if (bus.result !== 32'd21) begin n_bad++; $display("FAIL ignore_result: got %h want 15", bus.result); end
        if (bus.rd_out !== 5'd5) begin n_bad++; $display("FAIL ignore_rd: got %0d want 5", bus.rd_out); end
        @(posedge clk); #1;
        n_cmp += 2;
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL ignore_done_after: got %b want 0", bus.done); end
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ignore_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue(F3_DIVU, 32'd100, 32'd7, 5'd3);
        wait_done(lat, bc);
        n_cmp += 2;
        if (lat !== 33) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 33", lat); end
        if (bus.result !== 32'd14) begin n_bad++; $display("FAIL b2b_first_result: got %h want e", bus.result); end
        // Still in the DONE cycle: this request is accepted on the next edge.
        issue(F3_MUL, 32'd6, 32'd7, 5'd4);
        n_cmp += 2;
        if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy: got %b want 1", bus.busy); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL b2b_accept_done: got %b want 0", bus.done); end
        wait_done(lat, bc);
        n_cmp += 3;
        if (lat !== 33) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
        if (bus.result !== 32'd42) begin n_bad++; $display("FAIL b2b_second_result: got %h want 2a", bus.result); end
        if (bus.rd_out !== 5'd4) begin n_bad++; $display("FAIL b2b_second_rd: got %0d want 4", bus.rd_out); end
    endtask

    task automatic test_kill();
        bit seen = 1'b0;
        issue(F3_MUL, 32'd9, 32'd9, 5'd7);
        repeat (14) @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        n_cmp += 2;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL kill_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL kill_done: got %b want 0", bus.done); end
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        n_cmp += 3;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL kill_no_done: got %b want 0", seen); end
        if (bus.result !== 32'd42) begin n_bad++; $display("FAIL kill_result_hold: got %h want 2a", bus.result); end
        if (bus.rd_out !== 5'd4) begin n_bad++; $display("FAIL kill_rd_hold: got %0d want 4", bus.rd_out); end
        // kill and start on the same edge: kill wins.
        @(negedge clk);
        bus.kill = 1'b1;
        issue(F3_DIV, 32'd5, 32'd0, 5'd8);
        bus.kill = 1'b0;
        n_cmp += 2;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL killstart_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL killstart_done: got %b want 0", bus.done); end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        issue(F3_DIVU, 32'd1000, 32'd3, 5'd9);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
        if (bus.result !== 32'h0) begin n_bad++; $display("FAIL rstmid_result: got %h want 0", bus.result); end
        if (bus.rd_out !== 5'd0) begin n_bad++; $display("FAIL rstmid_rd: got %0d want 0", bus.rd_out); end
        @(negedge clk);
        rst_n = 1'b1;
        issue(F3_MUL, 32'd6, 32'd6, 5'd2);
        wait_done(lat, bc);
        n_cmp += 3;
        if (lat !== 33) begin n_bad++; $display("FAIL rstmid_mul_latency: got %0d want 33", lat); end
        if (bus.result !== 32'd36) begin n_bad++; $display("FAIL rstmid_mul_result: got %h want 24", bus.result); end
        if (bus.rd_out !== 5'd2) begin n_bad++; $display("FAIL rstmid_mul_rd: got %0d want 2", bus.rd_out); end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.rd_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();

        test_mul_basic();
        test_arith();
        test_special();
        test_start_ignored();
        test_back_to_back();
        test_kill();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
